// File: rtl/idex_pipe_pkg.sv
// idex_pipe_pkg: control bundle layout and ALUOp encodings shared by decode, ID/EX and ALU
package idex_pipe_pkg;
  localparam int CTRL_FLAGS = 4;
  localparam int GPRWR_BIT = 3;
  localparam int BSEL_BIT = 2;
  localparam int DMWR_BIT = 1;
  localparam int MTR_BIT = 0;
  localparam int ALUOP_LSB = 0;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;
  function automatic int ctrl_w(input int aluop_w);
    return CTRL_FLAGS + aluop_w;
  endfunction
endpackage

// File: rtl/idex_pipe_if.sv
// idex_pipe_if: ID/EX handshake and payload bundle; IDEX_FWD_EN adds rs/rt forwarding fields
interface idex_pipe_if #(parameter int DW = 32, parameter int RW = 5, parameter int ALUOP_W = 4);
  import idex_pipe_pkg::*;
  localparam int CTRL_W = ctrl_w(ALUOP_W);
  logic i_flush, i_valid, o_ready, o_valid, i_ready;
  logic [DW-1:0] i_busA, i_busB, i_imm32, i_pc;
  logic [DW-1:0] o_busA, o_busB, o_imm32, o_pc;
  logic [RW-1:0] i_rd, o_rd;
  logic [CTRL_W-1:0] i_signals;
  logic o_GPRWr, o_BSel, o_DMWr, o_MTR;
  logic [ALUOP_W-1:0] o_ALUOp;
`ifdef IDEX_FWD_EN
  logic [RW-1:0] i_rs, i_rt, o_rs, o_rt;
`endif
  modport slave (
`ifdef IDEX_FWD_EN
    input i_rs, i_rt, output o_rs, o_rt,
`endif
    input i_flush, i_valid, i_ready, i_busA, i_busB, i_imm32, i_pc, i_rd, i_signals,
    output o_ready, o_valid, o_busA, o_busB, o_imm32, o_pc, o_rd,
    output o_GPRWr, o_BSel, o_DMWr, o_MTR, o_ALUOp
  );
  modport master (
`ifdef IDEX_FWD_EN
    output i_rs, i_rt, input o_rs, o_rt,
`endif
    output i_flush, i_valid, i_ready, i_busA, i_busB, i_imm32, i_pc, i_rd, i_signals,
    input o_ready, o_valid, o_busA, o_busB, o_imm32, o_pc, o_rd,
    input o_GPRWr, o_BSel, o_DMWr, o_MTR, o_ALUOp
  );
endinterface

// File: rtl/idex_pipe_skid_reg.sv
// idex_pipe_skid_reg: generic two-entry valid/ready skid register with synchronous flush
module idex_pipe_skid_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic r_mv, r_sv, r_rdy;
  logic [W-1:0] r_main, r_skid;
  logic w_in, w_adv, w_sv_n;
  assign w_in = i_valid & r_rdy;
  assign w_adv = ~r_mv | i_ready;
  assign w_sv_n = w_adv ? (r_sv & w_in) : (r_sv | w_in);
  assign o_ready = r_rdy;
  assign o_valid = r_mv;
  assign o_data = r_main;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mv <= 1'b0;
      r_sv <= 1'b0;
      r_rdy <= 1'b0;
      r_main <= '0;
      r_skid <= '0;
    end else if (i_flush) begin
      r_mv <= 1'b0;
      r_sv <= 1'b0;
      r_rdy <= 1'b1;
    end else begin
      r_sv <= w_sv_n;
      r_rdy <= ~w_sv_n;
      if (w_adv) r_mv <= r_sv | w_in;
      if (w_adv && r_sv) r_main <= r_skid;
      else if (w_adv && w_in) r_main <= i_data;
      if (w_in && (r_sv || !w_adv)) r_skid <= i_data;
    end
  end
endmodule

// File: rtl/idex_pipe.sv
// idex_pipe: ID/EX stage register with skid buffering, flush and bubble masking; IDEX_FWD_EN carries rs/rt
module idex_pipe
  import idex_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int ALUOP_W = 4
) (
  input logic clk,
  input logic rst,
  idex_pipe_if.slave bus
);
  localparam int CTRL_W = ctrl_w(ALUOP_W);
  logic [CTRL_W-1:0] w_sig;
`ifdef IDEX_FWD_EN
  localparam int PW = 4 * DW + 3 * RW + CTRL_W;
  logic [RW-1:0] w_rs, w_rt;
  logic [PW-1:0] w_in, w_out;
  assign w_in = {bus.i_busA, bus.i_busB, bus.i_imm32, bus.i_pc, bus.i_rd, bus.i_rs, bus.i_rt, bus.i_signals};
  assign {bus.o_busA, bus.o_busB, bus.o_imm32, bus.o_pc, bus.o_rd, w_rs, w_rt, w_sig} = w_out;
  assign bus.o_rs = bus.o_valid ? w_rs : '0;
  assign bus.o_rt = bus.o_valid ? w_rt : '0;
`else
  localparam int PW = 4 * DW + RW + CTRL_W;
  logic [PW-1:0] w_in, w_out;
  assign w_in = {bus.i_busA, bus.i_busB, bus.i_imm32, bus.i_pc, bus.i_rd, bus.i_signals};
  assign {bus.o_busA, bus.o_busB, bus.o_imm32, bus.o_pc, bus.o_rd, w_sig} = w_out;
`endif
  idex_pipe_skid_reg #(.W(PW)) u_skid (
    .clk(clk),
    .rst(rst),
    .i_flush(bus.i_flush),
    .i_valid(bus.i_valid),
    .o_ready(bus.o_ready),
    .i_data(w_in),
    .o_valid(bus.o_valid),
    .i_ready(bus.i_ready),
    .o_data(w_out)
  );
  assign bus.o_GPRWr = w_sig[ALUOP_W+GPRWR_BIT] & bus.o_valid;
  assign bus.o_BSel = w_sig[ALUOP_W+BSEL_BIT];
  assign bus.o_DMWr = w_sig[ALUOP_W+DMWR_BIT] & bus.o_valid;
  assign bus.o_MTR = w_sig[ALUOP_W+MTR_BIT] & bus.o_valid;
  assign bus.o_ALUOp = w_sig[ALUOP_LSB+:ALUOP_W];
endmodule

// File: tb/tb_idex_pipe.sv
// tb_idex_pipe: directed checks of streaming, back-pressure, flush, decode, reset and optional IDEX_FWD_EN
module tb_idex_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  idex_pipe_if #(.DW(32), .RW(5), .ALUOP_W(4)) bus ();
  idex_pipe_if #(.DW(32), .RW(5), .ALUOP_W(5)) bus5 ();
  idex_pipe #(.DW(32), .RW(5), .ALUOP_W(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  idex_pipe #(.DW(32), .RW(5), .ALUOP_W(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] sig);
    bus.i_valid = v;
    bus.i_busA = a;
    bus.i_busB = a + 32'h100;
    bus.i_imm32 = ~a;
    bus.i_pc = a << 2;
    bus.i_rd = a[4:0];
    bus.i_signals = sig;
  endtask
  initial begin
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    drive(1'b0, 32'h0, 8'h00);
    bus5.i_flush = 1'b0;
    bus5.i_ready = 1'b1;
    bus5.i_valid = 1'b0;
    bus5.i_busA = '0;
    bus5.i_busB = '0;
    bus5.i_imm32 = '0;
    bus5.i_pc = '0;
    bus5.i_rd = '0;
    bus5.i_signals = '0;
`ifdef IDEX_FWD_EN
    bus.i_rs = '0;
    bus.i_rt = '0;
    bus5.i_rs = '0;
    bus5.i_rt = '0;
`endif
    step;
    step;
    chk("rst_valid", 64'(bus.o_valid), 0);
    chk("rst_ready", 64'(bus.o_ready), 0);
    chk("rst_busA", 64'(bus.o_busA), 0);
    chk("rst_aluop", 64'(bus.o_ALUOp), 0);
    rst = 1'b0;
    step;
    chk("rel_ready", 64'(bus.o_ready), 1);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h10 + k, 8'hB3);
      step;
      chk("str_valid", 64'(bus.o_valid), 1);
      chk("str_busA", 64'(bus.o_busA), 64'(32'h10 + k));
      chk("str_ready", 64'(bus.o_ready), 1);
    end
    chk("str_pc", 64'(bus.o_pc), 64'h5C);
    chk("str_rd", 64'(bus.o_rd), 64'h17);
    chk("str_imm", 64'(bus.o_imm32), 64'hFFFFFFE8);
    chk("str_busB", 64'(bus.o_busB), 64'h117);
    bus.i_valid = 1'b0;
    step;
    chk("bub_valid", 64'(bus.o_valid), 0);
    chk("bub_gprwr", 64'(bus.o_GPRWr), 0);
    chk("bub_dmwr", 64'(bus.o_DMWr), 0);
    chk("bub_mtr", 64'(bus.o_MTR), 0);
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h1, 8'hB3);
    step;
    chk("bp_a", 64'(bus.o_busA), 1);
    chk("bp_rdy1", 64'(bus.o_ready), 1);
    drive(1'b1, 32'h2, 8'hB3);
    step;
    chk("bp_full", 64'(bus.o_ready), 0);
    chk("bp_hold", 64'(bus.o_busA), 1);
    drive(1'b1, 32'h3, 8'hB3);
    step;
    chk("bp_hold2", 64'(bus.o_busA), 1);
    chk("bp_full2", 64'(bus.o_ready), 0);
    bus.i_ready = 1'b1;
    step;
    chk("bp_b", 64'(bus.o_busA), 2);
    chk("bp_rdy2", 64'(bus.o_ready), 1);
    step;
    chk("bp_c", 64'(bus.o_busA), 3);
    chk("bp_cvalid", 64'(bus.o_valid), 1);
    bus.i_valid = 1'b0;
    step;
    chk("bp_end", 64'(bus.o_valid), 0);
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h21, 8'hB3);
    step;
    drive(1'b1, 32'h22, 8'hB3);
    step;
    chk("fl_full", 64'(bus.o_ready), 0);
    bus.i_flush = 1'b1;
    drive(1'b1, 32'h3, 8'hB3);
    step;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("fl_valid", 64'(bus.o_valid), 0);
    chk("fl_ready", 64'(bus.o_ready), 1);
    chk("fl_gprwr", 64'(bus.o_GPRWr), 0);
    chk("fl_dmwr", 64'(bus.o_DMWr), 0);
    chk("fl_mtr", 64'(bus.o_MTR), 0);
    bus.i_ready = 1'b1;
    step;
    chk("fl_none", 64'(bus.o_valid), 0);
    bus.i_flush = 1'b1;
    drive(1'b1, 32'h33, 8'hB3);
    step;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("fl_drop", 64'(bus.o_valid), 0);
    drive(1'b1, 32'h50, 8'b1011_1010);
    bus5.i_valid = 1'b1;
    bus5.i_busA = 32'h55;
    bus5.i_signals = 9'b1_0_1_1_10110;
    step;
    bus5.i_valid = 1'b0;
    chk("dec_gprwr", 64'(bus.o_GPRWr), 1);
    chk("dec_bsel", 64'(bus.o_BSel), 0);
    chk("dec_dmwr", 64'(bus.o_DMWr), 1);
    chk("dec_mtr", 64'(bus.o_MTR), 1);
    chk("dec_aluop", 64'(bus.o_ALUOp), 64'hA);
    chk("a5_aluop", 64'(bus5.o_ALUOp), 64'h16);
    chk("a5_gprwr", 64'(bus5.o_GPRWr), 1);
    chk("a5_busA", 64'(bus5.o_busA), 64'h55);
    drive(1'b1, 32'h51, 8'b0100_0101);
    step;
    chk("dec2_gprwr", 64'(bus.o_GPRWr), 0);
    chk("dec2_bsel", 64'(bus.o_BSel), 1);
    chk("dec2_dmwr", 64'(bus.o_DMWr), 0);
    chk("dec2_mtr", 64'(bus.o_MTR), 0);
    chk("dec2_aluop", 64'(bus.o_ALUOp), 64'h5);
    bus.i_valid = 1'b0;
    step;
    bus.i_ready = 1'b0;
    drive(1'b1, 32'h41, 8'hBF);
    step;
    drive(1'b1, 32'h42, 8'hBF);
    step;
    chk("rm_full", 64'(bus.o_ready), 0);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    step;
    chk("rm_valid", 64'(bus.o_valid), 0);
    chk("rm_busA", 64'(bus.o_busA), 0);
    chk("rm_rd", 64'(bus.o_rd), 0);
    chk("rm_aluop", 64'(bus.o_ALUOp), 0);
    chk("rm_bsel", 64'(bus.o_BSel), 0);
    chk("rm_ready", 64'(bus.o_ready), 0);
    rst = 1'b0;
    step;
    chk("rm_rel", 64'(bus.o_ready), 1);
    chk("rm_relv", 64'(bus.o_valid), 0);
    bus.i_ready = 1'b1;
    step;
    chk("rm_empty", 64'(bus.o_valid), 0);
`ifdef IDEX_FWD_EN
    drive(1'b1, 32'h60, 8'hB3);
    bus.i_rs = 5'd5;
    bus.i_rt = 5'd9;
    step;
    chk("fw_rs", 64'(bus.o_rs), 5);
    chk("fw_rt", 64'(bus.o_rt), 9);
    chk("fw_rd", 64'(bus.o_rd), 0);
    bus.i_valid = 1'b0;
    step;
    chk("fw_bub_rs", 64'(bus.o_rs), 0);
    chk("fw_bub_rt", 64'(bus.o_rt), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
